l1_tlb: RTL and testbench

//  Fully associative L1 translation cache placed in front of the page-table walker (mmu), one per L1 port.

---
 rtl/l1_tlb_pkg.sv | 65 ++++++
 rtl/l1_tlb_if.sv | 45 ++++
 rtl/l1_tlb_match.sv | 37 +++
 rtl/l1_tlb.sv | 201 ++++++++++++++++++++
 tb/tb_l1_tlb.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/l1_tlb_pkg.sv
// Package: tlb_pkg
// Shared types for the L1 TLB slice: walker response layout, TLB entry
// layout, page-size encodings, FSM state enum and two small helpers
// (VPN compare mask per page size, physical address composition on a hit).
package tlb_pkg;

    localparam int PA_WIDTH = 56;
    localparam int PPN_W    = PA_WIDTH - 12;

    localparam logic [1:0] PGSZ_1G = 2'd0;
    localparam logic [1:0] PGSZ_2M = 2'd1;
    localparam logic [1:0] PGSZ_4K = 2'd2;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WALK_REQ  = 2'd1,
        WAIT_WALK = 2'd2
    } tlb_state_t;

    typedef struct packed {
        logic [PA_WIDTH-1:0] paddr;
        logic                fault;
        logic [1:0]          pgsize;
        logic                d;
        logic                r;
        logic                w;
        logic                x;
        logic                u;
    } page_walk_rsp_t;

    typedef struct packed {
        logic             valid;
        logic [26:0]      vpn;
        logic [1:0]       pgsize;
        logic [PPN_W-1:0] ppn;
        logic             d;
        logic             r;
        logic             w;
        logic             x;
        logic             u;
    } tlb_entry_t;

    // VPN bits that take part in the compare; superpages ignore the low levels.
    function automatic logic [26:0] vpn_mask(input logic [1:0] pgsize);
        logic [26:0] m;
        case (pgsize)
            PGSZ_1G: m = 27'h7FC_0000;
            PGSZ_2M: m = 27'h7FF_FE00;
            default: m = 27'h7FF_FFFF;
        endcase
        return m;
    endfunction

    // Superpages take more of the offset from the VA than 4K pages do.
    function automatic logic [PA_WIDTH-1:0] hit_pa(input logic [PPN_W-1:0] ppn,
                                                   input logic [1:0]       pgsize,
                                                   input logic [29:0]      va_lo);
        logic [PA_WIDTH-1:0] pa;
        pa = {ppn, va_lo[11:0]};
        if (pgsize == PGSZ_2M) pa[20:0] = va_lo[20:0];
        if (pgsize == PGSZ_1G) pa[29:0] = va_lo[29:0];
        return pa;
    endfunction

endpackage

// File: rtl/l1_tlb_if.sv
// Interface: l1_tlb_if
// Bundles the client request/response channel and the page-walker channel.
//  Client request : req_valid/req_va in, req_ready out.
//  Client response: rsp_valid one-cycle pulse with rsp_hit, rsp_pa, rsp_fault
//                   and PTE permission bits (no back-pressure on responses).
//  Walker         : walk_req one-cycle pulse with walk_va held stable until
//                   walk_rsp_valid; walk_rsp carries the walk result.
// Handshake: a request transfers on a cycle where req_valid & req_ready are
// both high; req_va must be stable while req_valid is high.
// Modports: slave = the TLB, master = the client/walker side.
interface l1_tlb_if;
    import tlb_pkg::*;

    logic                req_valid;
    logic [63:0]         req_va;
    logic                req_ready;
    logic                rsp_valid;
    logic                rsp_hit;
    logic [PA_WIDTH-1:0] rsp_pa;
    logic                rsp_fault;
    logic                rsp_dirty;
    logic                rsp_readable;
    logic                rsp_writable;
    logic                rsp_executable;
    logic                rsp_user;
    logic                walk_req;
    logic [63:0]         walk_va;
    logic                walk_rsp_valid;
    page_walk_rsp_t      walk_rsp;

    modport slave (
        input  req_valid, req_va, walk_rsp_valid, walk_rsp,
        output req_ready, rsp_valid, rsp_hit, rsp_pa, rsp_fault, rsp_dirty,
               rsp_readable, rsp_writable, rsp_executable, rsp_user,
               walk_req, walk_va
    );

    modport master (
        output req_valid, req_va, walk_rsp_valid, walk_rsp,
        input  req_ready, rsp_valid, rsp_hit, rsp_pa, rsp_fault, rsp_dirty,
               rsp_readable, rsp_writable, rsp_executable, rsp_user,
               walk_req, walk_va
    );

endinterface

// File: rtl/l1_tlb_match.sv
// Module: tlb_match
// Combinational associative lookup: compares the request VPN against every
// entry using the entry's page-size mask.
//  i_valid/i_vpn/i_pgsize : per-entry tag fields
//  i_va_vpn               : va[38:12] of the request
//  i_canonical            : request VA is canonical (non-canonical never hits)
//  o_hit_vec              : one-hot hit vector
//  o_hit / o_hit_idx      : any hit, encoded index of the hitting entry
module tlb_match
    import tlb_pkg::*;
#(
    parameter int N_ENTRIES = 8
) (
    input  logic [N_ENTRIES-1:0]                 i_valid,
    input  logic [N_ENTRIES-1:0][26:0]           i_vpn,
    input  logic [N_ENTRIES-1:0][1:0]            i_pgsize,
    input  logic [26:0]                          i_va_vpn,
    input  logic                                 i_canonical,
    output logic [N_ENTRIES-1:0]                 o_hit_vec,
    output logic                                 o_hit,
    output logic [$clog2(N_ENTRIES)-1:0]         o_hit_idx
);
    localparam int IW = $clog2(N_ENTRIES);

    always_comb begin
        o_hit_vec = '0;
        o_hit_idx = '0;
        for (int i = 0; i < N_ENTRIES; i++) begin
            o_hit_vec[i] = i_valid[i] && i_canonical &&
                           (((i_vpn[i] ^ i_va_vpn) & vpn_mask(i_pgsize[i])) == 27'd0);
            // OR-encode: exact while the vector is one-hot.
            if (o_hit_vec[i]) o_hit_idx = o_hit_idx | IW'(i);
        end
        o_hit = |o_hit_vec;
    end

endmodule

// File: rtl/l1_tlb.sv
// Module: l1_tlb
// Fully associative L1 TLB in front of the page-table walker. Hits respond one
// cycle after acceptance; misses issue one walk, respond one cycle after the
// walk result, and fill a victim entry unless the walk faulted or a clear
// intervened.
// Ports:
//  clk, reset     : clock, synchronous active-high reset
//  i_clear_tlb    : invalidate all entries
//  bus            : l1_tlb_if.slave (client request/response + walker)
//  o_hit_count    : hit responses (TLB_STATS_EN), else 0
//  o_miss_count   : walk responses (TLB_STATS_EN), else 0
//  o_state        : current FSM state (debug)
// Build option: TLB_STATS_EN enables the statistics counters.
module l1_tlb
    import tlb_pkg::*;
#(
    parameter int N_ENTRIES = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_clear_tlb,
    l1_tlb_if.slave     bus,
    output logic [31:0] o_hit_count,
    output logic [31:0] o_miss_count,
    output tlb_state_t  o_state
);
    localparam int IW = $clog2(N_ENTRIES);

    tlb_entry_t [N_ENTRIES-1:0]       r_entries;
    logic [IW-1:0]                    r_rr_ptr;
    tlb_state_t                       r_state;
    tlb_state_t                       w_state_next;
    logic [63:0]                      r_va;
    logic                             r_kill;
    logic                             r_walk_req;

    logic                             r_rsp_valid, r_rsp_hit, r_rsp_fault;
    logic [PA_WIDTH-1:0]              r_rsp_pa;
    logic                             r_d, r_r, r_w, r_x, r_u;

    logic [N_ENTRIES-1:0]             w_valid;
    logic [N_ENTRIES-1:0][26:0]       w_vpn;
    logic [N_ENTRIES-1:0][1:0]        w_pgsize;
    logic [N_ENTRIES-1:0]             w_hit_vec;
    logic                             w_hit;
    logic [IW-1:0]                    w_hit_idx;
    logic                             w_canonical;
    logic                             w_accept, w_hit_rsp, w_walk_done, w_fill;
    logic [IW-1:0]                    w_victim;
    logic                             w_use_rr;
    logic                             w_unused;

    assign w_unused = ^bus.walk_rsp.paddr[11:0];

    always_comb begin
        for (int i = 0; i < N_ENTRIES; i++) begin
            w_valid[i]  = r_entries[i].valid;
            w_vpn[i]    = r_entries[i].vpn;
            w_pgsize[i] = r_entries[i].pgsize;
        end
    end

    assign w_canonical = (&bus.req_va[63:38]) | ~(|bus.req_va[63:38]);

    tlb_match #(.N_ENTRIES(N_ENTRIES)) u_match (
        .i_valid     (w_valid),
        .i_vpn       (w_vpn),
        .i_pgsize    (w_pgsize),
        .i_va_vpn    (bus.req_va[38:12]),
        .i_canonical (w_canonical),
        .o_hit_vec   (w_hit_vec),
        .o_hit       (w_hit),
        .o_hit_idx   (w_hit_idx)
    );

    assign bus.req_ready = (r_state == IDLE) && !i_clear_tlb;
    assign w_accept      = bus.req_valid && bus.req_ready;
    assign w_hit_rsp     = w_accept && w_hit;
    assign w_walk_done   = (r_state == WAIT_WALK) && bus.walk_rsp_valid;
    // A clear in the same cycle as the fill wins over the fill.
    assign w_fill        = w_walk_done && !bus.walk_rsp.fault && !r_kill && !i_clear_tlb;

    // Victim: lowest-index invalid entry, otherwise the round-robin pointer.
    always_comb begin
        w_victim = r_rr_ptr;
        w_use_rr = 1'b1;
        for (int i = N_ENTRIES - 1; i >= 0; i--) begin
            if (!r_entries[i].valid) begin
                w_victim = IW'(i);
                w_use_rr = 1'b0;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:      if (w_accept && !w_hit) w_state_next = WALK_REQ;
            WALK_REQ:  w_state_next = WAIT_WALK;
            WAIT_WALK: if (bus.walk_rsp_valid) w_state_next = IDLE;
            default:   w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_va       <= '0;
            r_kill     <= 1'b0;
            r_walk_req <= 1'b0;
            r_rr_ptr   <= '0;
            r_entries  <= '0;
        end else begin
            r_walk_req <= (r_state == WALK_REQ);
            if (w_accept && !w_hit) r_va <= bus.req_va;
            // Kill is sticky for the walk in flight and dropped on return to IDLE.
            if (w_walk_done)                        r_kill <= 1'b0;
            else if (i_clear_tlb && r_state != IDLE) r_kill <= 1'b1;
            if (i_clear_tlb) begin
                for (int i = 0; i < N_ENTRIES; i++) r_entries[i].valid <= 1'b0;
            end else if (w_fill) begin
                r_entries[w_victim] <= '{valid:  1'b1,
                                         vpn:    r_va[38:12],
                                         pgsize: bus.walk_rsp.pgsize,
                                         ppn:    bus.walk_rsp.paddr[PA_WIDTH-1:12],
                                         d: bus.walk_rsp.d, r: bus.walk_rsp.r,
                                         w: bus.walk_rsp.w, x: bus.walk_rsp.x,
                                         u: bus.walk_rsp.u};
                if (w_use_rr) r_rr_ptr <= r_rr_ptr + IW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rsp_valid <= 1'b0;
            r_rsp_hit   <= 1'b0;
            r_rsp_fault <= 1'b0;
            r_rsp_pa    <= '0;
            {r_d, r_r, r_w, r_x, r_u} <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            if (w_hit_rsp) begin
                r_rsp_valid <= 1'b1;
                r_rsp_hit   <= 1'b1;
                r_rsp_fault <= 1'b0;
                r_rsp_pa    <= hit_pa(r_entries[w_hit_idx].ppn, r_entries[w_hit_idx].pgsize,
                                      bus.req_va[29:0]);
                {r_d, r_r, r_w, r_x, r_u} <= {r_entries[w_hit_idx].d, r_entries[w_hit_idx].r,
                                              r_entries[w_hit_idx].w, r_entries[w_hit_idx].x,
                                              r_entries[w_hit_idx].u};
            end else if (w_walk_done) begin
                r_rsp_valid <= 1'b1;
                r_rsp_hit   <= 1'b0;
                r_rsp_fault <= bus.walk_rsp.fault;
                r_rsp_pa    <= {bus.walk_rsp.paddr[PA_WIDTH-1:12], r_va[11:0]};
                {r_d, r_r, r_w, r_x, r_u} <= {bus.walk_rsp.d, bus.walk_rsp.r, bus.walk_rsp.w,
                                              bus.walk_rsp.x, bus.walk_rsp.u};
            end
        end
    end

`ifdef TLB_STATS_EN
    logic [31:0] r_hit_count, r_miss_count;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            if (w_hit_rsp)   r_hit_count  <= r_hit_count + 32'd1;
            if (w_walk_done) r_miss_count <= r_miss_count + 32'd1;
        end
    end
    assign o_hit_count  = r_hit_count;
    assign o_miss_count = r_miss_count;
`else
    assign o_hit_count  = 32'd0;
    assign o_miss_count = 32'd0;
`endif

    assign bus.rsp_valid      = r_rsp_valid;
    assign bus.rsp_hit        = r_rsp_hit;
    assign bus.rsp_pa         = r_rsp_pa;
    assign bus.rsp_fault      = r_rsp_fault;
    assign bus.rsp_dirty      = r_d;
    assign bus.rsp_readable   = r_r;
    assign bus.rsp_writable   = r_w;
    assign bus.rsp_executable = r_x;
    assign bus.rsp_user       = r_u;
    assign bus.walk_req       = r_walk_req;
    assign bus.walk_va        = r_va;
    assign o_state            = r_state;

    // Two entries matching one VA means a fill went wrong.
    a_one_hit: assert property (@(posedge clk) disable iff (reset) $onehot0(w_hit_vec));

endmodule

// File: tb/tb_l1_tlb.sv
// Testbench for l1_tlb: directed translation scenarios with a scoreboard of
// expected responses and a walker driven from the request task.
module tb_l1_tlb;
  import tlb_pkg::*;

  localparam int EW = 63;  // {hit, fault, pa[55:0], d,r,w,x,u}

  logic clk;
  logic reset;
  logic clear_tlb;
  logic [31:0] hit_count, miss_count;
  tlb_state_t dbg_state;

  l1_tlb_if tif ();

  l1_tlb #(.N_ENTRIES(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_clear_tlb  (clear_tlb),
    .bus          (tif.slave),
    .o_hit_count  (hit_count),
    .o_miss_count (miss_count),
    .o_state      (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  int n_checks = 0;
  int n_errors = 0;
  int walk_cnt = 0;
  int rsp_cnt  = 0;
  logic [EW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // scoreboard: compare every response against the head of the queue
  always @(negedge clk) begin
    if (!reset && tif.rsp_valid) begin
      rsp_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", 64'd1, 64'd0);
      end else begin
        check("rsp", 64'({tif.rsp_hit, tif.rsp_fault, tif.rsp_pa, tif.rsp_dirty,
                          tif.rsp_readable, tif.rsp_writable, tif.rsp_executable,
                          tif.rsp_user}), 64'(exp_q.pop_front()));
      end
    end
    if (tif.walk_req) walk_cnt++;
  end

  // driver tasks
  task automatic pulse_clear();
    @(negedge clk); clear_tlb = 1'b1;
    @(negedge clk); clear_tlb = 1'b0;
  endtask

  task automatic do_req(input logic [63:0] va, input logic exp_hit,
                        input logic [55:0] paddr, input logic [1:0] pgsz,
                        input logic fault, input logic [4:0] perms,
                        input logic [55:0] exp_pa, input logic do_clear);
    int w0;
    int lat;
    int n;
    page_walk_rsp_t wr;
    w0 = walk_cnt;
    @(negedge clk);
    check("req_ready", 64'(tif.req_ready), 64'd1);
    tif.req_valid = 1'b1;
    tif.req_va = va;
    exp_q.push_back({exp_hit, exp_hit ? 1'b0 : fault, exp_pa, perms});
    @(negedge clk);
    tif.req_valid = 1'b0;
    lat = 1;
    if (exp_hit) begin
      check("hit_latency", 64'(tif.rsp_valid), 64'd1);
    end else begin
      while (!tif.walk_req && lat < 20) begin
        @(negedge clk);
        lat++;
      end
      check("walk_req_seen", 64'(tif.walk_req), 64'd1);
      check("walk_latency", 64'(lat), 64'd2);
      check("walk_va", tif.walk_va, va);
      @(negedge clk);
      if (do_clear) pulse_clear();
      wr.paddr = paddr;
      wr.fault = fault;
      wr.pgsize = pgsz;
      {wr.d, wr.r, wr.w, wr.x, wr.u} = perms;
      tif.walk_rsp = wr;
      tif.walk_rsp_valid = 1'b1;
      @(negedge clk);
      tif.walk_rsp_valid = 1'b0;
      check("miss_rsp_latency", 64'(tif.rsp_valid), 64'd1);
    end
    #1;
    n = 0;
    while (exp_q.size() != 0 && n < 10) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("rsp_delivered", 64'(exp_q.size()), 64'd0);
    check("walk_count", 64'(walk_cnt - w0), exp_hit ? 64'd0 : 64'd1);
  endtask

  initial begin
    int r0;
    int n;
    reset = 1'b1;
    clear_tlb = 1'b0;
    tif.req_valid = 1'b0;
    tif.req_va = '0;
    tif.walk_rsp_valid = 1'b0;
    tif.walk_rsp = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rsp_valid", 64'(tif.rsp_valid), 64'd0);
    check("rst_walk_req", 64'(tif.walk_req), 64'd0);
    check("rst_rsp_pa", 64'(tif.rsp_pa), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(IDLE));
    check("rst_hit_count", 64'(hit_count), 64'd0);
    check("rst_miss_count", 64'(miss_count), 64'd0);
    reset = 1'b0;

    // 1: 4K fill then hit
    do_req(64'h4000_1234, 1'b0, 56'h8765_4000, PGSZ_4K, 1'b0, 5'b11011, 56'h8765_4234, 1'b0);
    do_req(64'h4000_1234, 1'b1, '0, '0, 1'b0, 5'b11011, 56'h8765_4234, 1'b0);

    // 2: 2M superpage
    do_req(64'h0020_0000, 1'b0, 56'h8020_0000, PGSZ_2M, 1'b0, 5'b01101, 56'h8020_0000, 1'b0);
    do_req(64'h003F_F008, 1'b1, '0, '0, 1'b0, 5'b01101, 56'h803F_F008, 1'b0);

`ifdef TLB_STATS_EN
    check("hit_count", 64'(hit_count), 64'd2);
    check("miss_count", 64'(miss_count), 64'd2);
`else
    check("hit_count_off", 64'(hit_count), 64'd0);
    check("miss_count_off", 64'(miss_count), 64'd0);
`endif

    // 3: walker fault is forwarded and not filled
    do_req(64'h1000, 1'b0, 56'h0, PGSZ_4K, 1'b1, 5'b00000, 56'h0, 1'b0);
    do_req(64'h1000, 1'b0, 56'h0, PGSZ_4K, 1'b1, 5'b00000, 56'h0, 1'b0);

    // 4: replacement with 9 distinct 4K pages into 8 entries
    pulse_clear();
    for (int i = 0; i < 9; i++)
      do_req(64'h1000_0010 + 64'(i) * 64'h1000, 1'b0, 56'hA000_0000 + 56'(i) * 56'h1000,
             PGSZ_4K, 1'b0, 5'b01010, 56'hA000_0010 + 56'(i) * 56'h1000, 1'b0);
    for (int i = 1; i < 9; i++)
      do_req(64'h1000_0010 + 64'(i) * 64'h1000, 1'b1, '0, '0, 1'b0, 5'b01010,
             56'hA000_0010 + 56'(i) * 56'h1000, 1'b0);
    do_req(64'h1000_0010, 1'b0, 56'hA000_0000, PGSZ_4K, 1'b0, 5'b01010, 56'hA000_0010, 1'b0);

    // 5: clear during the walk: response still returned, fill suppressed
    do_req(64'h5000, 1'b0, 56'h9000_5000, PGSZ_4K, 1'b0, 5'b11111, 56'h9000_5000, 1'b1);
    do_req(64'h5000, 1'b0, 56'h9000_5000, PGSZ_4K, 1'b0, 5'b11111, 56'h9000_5000, 1'b0);
    do_req(64'h5abc, 1'b1, '0, '0, 1'b0, 5'b11111, 56'h9000_5abc, 1'b0);

    // 6: non-canonical VA never hits the VPN-0 entry
    do_req(64'h0, 1'b0, 56'hC000_0000, PGSZ_4K, 1'b0, 5'b01100, 56'hC000_0000, 1'b0);
    do_req(64'h123, 1'b1, '0, '0, 1'b0, 5'b01100, 56'hC000_0123, 1'b0);
    do_req(64'h0000_0080_0000_0000, 1'b0, 56'h0, PGSZ_4K, 1'b1, 5'b00000, 56'h0, 1'b0);

    // reset mid-walk: the late walker response is ignored
    @(negedge clk);
    tif.req_valid = 1'b1;
    tif.req_va = 64'h7000;
    @(negedge clk);
    tif.req_valid = 1'b0;
    n = 0;
    while (!tif.walk_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rst_walk_seen", 64'(tif.walk_req), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid_state", 64'(dbg_state), 64'(IDLE));
    r0 = rsp_cnt;
    tif.walk_rsp = '0;
    tif.walk_rsp_valid = 1'b1;
    @(negedge clk);
    tif.walk_rsp_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("late_walk_ignored", 64'(rsp_cnt - r0), 64'd0);
    check("rst_mid_ready", 64'(tif.req_ready), 64'd1);
    // entries were invalidated by reset: VPN 0 walks again
    do_req(64'h0, 1'b0, 56'hC000_0000, PGSZ_4K, 1'b0, 5'b01100, 56'hC000_0000, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
